gpio_apb_irq: RTL

Parametrised APB GPIO peripheral with input synchronisation and per-pin interrupt generation. It provides WIDTH pins of output data, direction and synchronised input, plus atomic set/clear of outputs and maskable level- or edge-triggered interrupts per pin. It sits on the peripheral APB bus, with gpi/gpo/gpd going to the pad ring and gpio_intr going to the interrupt controller.

---
 rtl/gpio_apb_pkg.sv | 36 +++
 rtl/gpio_sync_edge.sv | 39 +++
 rtl/gpio_apb_irq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/gpio_apb_pkg.sv
// Shared definitions for the APB GPIO block: register offsets, parameter
// range limits, the decoded write payload and the byte-lane mask helper.
package gpio_apb_pkg;

  localparam int unsigned APB_DW = 32;

  localparam logic [7:0] GPO_OFS      = 8'h00;
  localparam logic [7:0] GPI_OFS      = 8'h04;
  localparam logic [7:0] GPO_SET_OFS  = 8'h08;
  localparam logic [7:0] GPD_OFS      = 8'h0C;
  localparam logic [7:0] GPO_CLR_OFS  = 8'h10;
  localparam logic [7:0] IRQ_EN_OFS   = 8'h14;
  localparam logic [7:0] IRQ_TYPE_OFS = 8'h18;
  localparam logic [7:0] IRQ_POL_OFS  = 8'h1C;
  localparam logic [7:0] IRQ_STAT_OFS = 8'h20;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 32;
  localparam int unsigned SYNC_MIN  = 2;
  localparam int unsigned SYNC_MAX  = 3;

  // Decoded APB write: offset, raw data and per-bit lane enable.
  typedef struct packed {
    logic [7:0]        ofs;
    logic [APB_DW-1:0] data;
    logic [APB_DW-1:0] lanes;
  } apb_wr_t;

  // Expand the 4 byte strobes into a 32-bit bit-enable mask.
  function automatic logic [APB_DW-1:0] strb_mask(input logic [3:0] strb);
    logic [APB_DW-1:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser for the GPIO pads plus a one-cycle delayed copy used
// for edge detection.
//   clock, rst_n : clock, async active-low reset
//   gpi_i        : asynchronous pad inputs
//   s_o          : synchronised inputs (last synchroniser stage)
//   rise_c_o     : s went 0->1 this cycle (combinational from flops)
//   fall_c_o     : s went 1->0 this cycle (combinational from flops)
module gpio_sync_edge #(
  parameter int unsigned WIDTH       = 20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpi_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] rise_c_o,
  output logic [WIDTH-1:0] fall_c_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  // Synchroniser chain and previous-value flop.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpi_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o      = sync_q[SYNC_STAGES-1];
  assign rise_c_o = s_o & ~prev_q;
  assign fall_c_o = ~s_o & prev_q;

endmodule

// File: rtl/gpio_apb_irq.sv
// APB GPIO peripheral: output data/enable registers with atomic set/clear,
// synchronised inputs and per-pin maskable level/edge interrupts.
//   clock, rst_n        : clock, async active-low reset
//   apb_addr/sel/write/ena/wdata/pstb : APB request (only addr[7:0] decoded)
//   apb_rdata           : registered read data
//   apb_rready          : always 1, no wait states
//   gpio_intr           : |(IRQ_STAT & IRQ_EN)
//   gpi                 : asynchronous pad inputs
//   gpo, gpd            : pad output data and output enable
module gpio_apb_irq
  import gpio_apb_pkg::*;
#(
  parameter int unsigned WIDTH       = 20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [31:0]      apb_addr,
  input  logic             apb_sel,
  input  logic             apb_write,
  input  logic             apb_ena,
  input  logic [31:0]      apb_wdata,
  output logic [31:0]      apb_rdata,
  input  logic [3:0]       apb_pstb,
  output logic             apb_rready,
  output logic             gpio_intr,
  input  logic [WIDTH-1:0] gpi,
  output logic [WIDTH-1:0] gpo,
  output logic [WIDTH-1:0] gpd
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_param_err
    $error("gpio_apb_irq: WIDTH or SYNC_STAGES out of range");
  end

  logic [WIDTH-1:0] gpo_q, gpo_d;
  logic [WIDTH-1:0] gpd_q, gpd_d;
  logic [WIDTH-1:0] en_q, en_d;
  logic [WIDTH-1:0] type_q, type_d;
  logic [WIDTH-1:0] pol_q, pol_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [WIDTH-1:0] s_c, rise_c, fall_c;
  logic [WIDTH-1:0] lane_c, ones_c, w1c_c, evt_c;
  logic             wr_en_c;
  apb_wr_t          wr_c;
  logic             unused_bits;

  gpio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .rst_n   (rst_n),
    .gpi_i   (gpi),
    .s_o     (s_c),
    .rise_c_o(rise_c),
    .fall_c_o(fall_c)
  );

  assign wr_c    = '{ofs: apb_addr[7:0], data: apb_wdata, lanes: strb_mask(apb_pstb)};
  assign wr_en_c = apb_sel & apb_ena & apb_write;
  assign lane_c  = WIDTH'(wr_c.lanes);
  // Bits written as 1 on an enabled lane: drives SET, CLR and W1C.
  assign ones_c  = WIDTH'(wr_c.data) & lane_c;
  assign unused_bits = ^{apb_addr[31:8], wr_c};

  // Register decode, interrupt status update and read mux.
  always_comb begin
    gpo_d   = gpo_q;
    gpd_d   = gpd_q;
    en_d    = en_q;
    type_d  = type_q;
    pol_d   = pol_q;
    rdata_d = rdata_q;
    w1c_c   = '0;

    if (wr_en_c) begin
      case (wr_c.ofs)
        GPO_OFS:      gpo_d  = (gpo_q  & ~lane_c) | ones_c;
        GPO_SET_OFS:  gpo_d  = gpo_q | ones_c;
        GPO_CLR_OFS:  gpo_d  = gpo_q & ~ones_c;
        GPD_OFS:      gpd_d  = (gpd_q  & ~lane_c) | ones_c;
        IRQ_EN_OFS:   en_d   = (en_q   & ~lane_c) | ones_c;
        IRQ_TYPE_OFS: type_d = (type_q & ~lane_c) | ones_c;
        IRQ_POL_OFS:  pol_d  = (pol_q  & ~lane_c) | ones_c;
        IRQ_STAT_OFS: w1c_c  = ones_c;
        default: ;
      endcase
    end

    // Edge bits are sticky with set priority over W1C; level bits track the pin.
    evt_c  = (pol_q & rise_c) | (~pol_q & fall_c);
    stat_d = (type_q & (evt_c | (stat_q & ~w1c_c))) | (~type_q & ~(s_c ^ pol_q));

    if (apb_sel && !apb_write) begin
      case (wr_c.ofs)
        GPO_OFS:      rdata_d = 32'(gpo_q);
        GPI_OFS:      rdata_d = 32'(s_c);
        GPD_OFS:      rdata_d = 32'(gpd_q);
        IRQ_EN_OFS:   rdata_d = 32'(en_q);
        IRQ_TYPE_OFS: rdata_d = 32'(type_q);
        IRQ_POL_OFS:  rdata_d = 32'(pol_q);
        IRQ_STAT_OFS: rdata_d = 32'(stat_q);
        default:      rdata_d = '0;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      gpo_q   <= '0;
      gpd_q   <= '0;
      en_q    <= '0;
      type_q  <= '0;
      pol_q   <= '0;
      stat_q  <= '0;
      rdata_q <= '0;
    end else begin
      gpo_q   <= gpo_d;
      gpd_q   <= gpd_d;
      en_q    <= en_d;
      type_q  <= type_d;
      pol_q   <= pol_d;
      stat_q  <= stat_d;
      rdata_q <= rdata_d;
    end
  end

  assign gpo        = gpo_q;
  assign gpd        = gpd_q;
  assign apb_rdata  = rdata_q;
  assign apb_rready = 1'b1;
  assign gpio_intr  = |(stat_q & en_q);

endmodule
